// File: rtl/dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : dcache_direct_mapped
// Description : Direct-mapped, write-back, write-allocate byte-wide data cache
//               in front of a 4-byte-block data memory. Hits complete in the
//               request cycle; misses stall the CPU via o_busywait while the
//               line is written back (if dirty) and refilled.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 3,
  parameter int ADDR_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_read,
  input  logic                 i_write,
  input  logic [ADDR_BITS-1:0] i_address,
  input  logic [7:0]           i_writedata,
  output logic [7:0]           o_readdata,
  output logic                 o_busywait,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic [ADDR_BITS-3:0] o_mem_address,
  output logic [31:0]          o_mem_writedata,
  input  logic [31:0]          i_mem_readdata,
  input  logic                 i_mem_busywait
);

  localparam int NUM_LINES = 2 ** INDEX_BITS;
  localparam int TAG_BITS  = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FETCH     = 2'd2,
    S_UPDATE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Line bookkeeping; valid/dirty are reset, tag/data arrays are not.
  logic [NUM_LINES-1:0]  r_valid;
  logic [NUM_LINES-1:0]  r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [NUM_LINES];
  logic [31:0]           r_data [NUM_LINES];

  // Miss context captured when leaving IDLE, plus the fetched block.
  logic [TAG_BITS-1:0]   r_miss_tag;
  logic [INDEX_BITS-1:0] r_miss_index;
  logic [31:0]           r_fill_data;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_offset;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_victim_dirty;
  logic                  w_write_hit;
  logic [31:0]           w_line;
  logic [7:0]            w_byte;

  assign w_tag          = i_address[ADDR_BITS-1:INDEX_BITS+2];
  assign w_index        = i_address[INDEX_BITS+1:2];
  assign w_offset       = i_address[1:0];
  assign w_req          = i_read | i_write;
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victim_dirty = r_valid[w_index] & r_dirty[w_index];
  assign w_line         = r_data[w_index];
  assign w_byte         = w_line[{w_offset, 3'b000} +: 8];
  // A simultaneous read and write is serviced as a write.
  assign w_write_hit    = (r_state == S_IDLE) && i_write && w_hit;

  // State register plus reset-cleared line status and miss context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_fill_data  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_write_hit) begin
        r_dirty[w_index] <= 1'b1;
      end
      if ((r_state == S_IDLE) && w_req && !w_hit) begin
        r_miss_tag   <= w_tag;
        r_miss_index <= w_index;
      end
      if ((r_state == S_FETCH) && !i_mem_busywait) begin
        r_fill_data <= i_mem_readdata;
      end
      if (r_state == S_UPDATE) begin
        r_valid[r_miss_index] <= 1'b1;
        r_dirty[r_miss_index] <= 1'b0;
      end
    end
  end

  // Tag/data arrays: whole-line refill in UPDATE, single-byte store on a write hit.
  // Reset forces IDLE and clears valid, so neither write can fire under reset.
  always_ff @(posedge clk) begin
    if (r_state == S_UPDATE) begin
      r_data[r_miss_index] <= r_fill_data;
      r_tag[r_miss_index]  <= r_miss_tag;
    end else if (w_write_hit) begin
      r_data[w_index][{w_offset, 3'b000} +: 8] <= i_writedata;
    end
  end

  // Next-state and output decode; memory request held until memory drops busywait.
  always_comb begin
    w_next_state    = r_state;
    o_busywait      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_address   = '0;
    o_mem_writedata = '0;
    o_readdata      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            if (!i_write) begin
              o_readdata = w_byte;
            end
          end else begin
            o_busywait   = 1'b1;
            w_next_state = w_victim_dirty ? S_WRITEBACK : S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        o_busywait      = 1'b1;
        o_mem_write     = 1'b1;
        o_mem_address   = {r_tag[r_miss_index], r_miss_index};
        o_mem_writedata = r_data[r_miss_index];
        if (!i_mem_busywait) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        o_busywait    = 1'b1;
        o_mem_read    = 1'b1;
        o_mem_address = {r_miss_tag, r_miss_index};
        if (!i_mem_busywait) begin
          w_next_state = S_UPDATE;
        end
      end
      S_UPDATE: begin
        o_busywait   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    // A held request must not show a stall while reset is asserted.
    if (!rst_n) begin
      o_busywait = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_direct_mapped
// Description : Self-checking bench for dcache_direct_mapped. A behavioural
//               cache/memory model predicts CPU responses, stall counts and
//               memory transactions; a monitor compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_direct_mapped;

  localparam int TMEM = 3;  // memory latency in cycles per block transfer

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic        i_write;
  logic [7:0]  i_address;
  logic [7:0]  i_writedata;
  logic [7:0]  o_readdata;
  logic        o_busywait;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [5:0]  o_mem_address;
  logic [31:0] o_mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  always #5 clk = ~clk;

  dcache_direct_mapped #(.INDEX_BITS(3), .ADDR_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_read         (i_read),
    .i_write        (i_write),
    .i_address      (i_address),
    .i_writedata    (i_writedata),
    .o_readdata     (o_readdata),
    .o_busywait     (o_busywait),
    .o_mem_read     (o_mem_read),
    .o_mem_write    (o_mem_write),
    .o_mem_address  (o_mem_address),
    .o_mem_writedata(o_mem_writedata),
    .i_mem_readdata (mem_readdata),
    .i_mem_busywait (mem_busywait)
  );

  // Initial memory contents: a fixed hash of the block address.
  function automatic logic [31:0] init_blk(input logic [5:0] a);
    return ({26'd0, a} * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  // ---------------- block memory ----------------
  logic [31:0] wmem     [64];
  bit          mwritten [64];
  int          mem_cnt = 0;

  assign mem_busywait = (o_mem_read || o_mem_write) && (mem_cnt < TMEM - 1);
  always_comb mem_readdata = mwritten[o_mem_address] ? wmem[o_mem_address]
                                                      : init_blk(o_mem_address);

  initial begin : memory
    forever begin
      @(posedge clk);
      if (o_mem_read || o_mem_write) begin
        if (!mem_busywait) begin
          mem_cnt <= 0;
          if (o_mem_write) begin
            wmem[o_mem_address]     <= o_mem_writedata;
            mwritten[o_mem_address] <= 1'b1;
          end
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct {
    bit          rd;
    logic [7:0]  addr;
    logic [7:0]  data;
    int          stalls;
  } opx_t;

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } memx_t;

  opx_t  op_q  [$];
  memx_t mem_q [$];

  // Driver-owned handshake variables read by the monitor.
  logic [48:0] snap_val = '0;
  int          snap_req = 0;
  bit          mon_en   = 1'b1;
  bit          done_req = 1'b0;

  // ---------------- reference model ----------------
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_line  [8];
  logic [31:0] ref_mem [64];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output logic [7:0] rdata, output int stalls);
    int         idx;
    int         off;
    logic [2:0] tg;
    memx_t      mx;
    idx    = int'(a[4:2]);
    off    = int'(a[1:0]);
    tg     = a[7:5];
    stalls = 0;
    rdata  = 8'h00;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        mx.wr   = 1'b1;
        mx.addr = {m_tag[idx], 3'(idx)};
        mx.data = m_line[idx];
        mem_q.push_back(mx);
        ref_mem[mx.addr] = m_line[idx];
        stalls += TMEM;
      end
      mx.wr   = 1'b0;
      mx.addr = {tg, 3'(idx)};
      mx.data = 32'h0;
      mem_q.push_back(mx);
      m_line[idx]  = ref_mem[mx.addr];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      stalls += TMEM + 2;
    end
    if (wr) begin
      m_line[idx][off*8 +: 8] = d;
      m_dirty[idx] = 1'b1;
    end else begin
      rdata = m_line[idx][off*8 +: 8];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_done(input logic [7:0] a);
    bit ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!o_busywait) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL op_timeout addr=%h busywait=%b required 0 within 40 cycles", a, o_busywait);
      $fatal(1);
    end
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] er;
    int         st;
    opx_t       o;
    model_op(wr, a, d, er, st);
    o.rd     = !wr;
    o.addr   = a;
    o.data   = er;
    o.stalls = st;
    op_q.push_back(o);
    @(posedge clk);
    #1;
    i_read      = rd;
    i_write     = wr;
    i_address   = a;
    i_writedata = d;
    wait_done(a);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    i_read  = 1'b0;
    i_write = 1'b0;
  endtask

  task automatic take_snapshot();
    snap_val = {o_busywait, o_mem_read, o_mem_write, o_readdata, o_mem_address, o_mem_writedata};
    snap_req = snap_req + 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    bit         seen;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_blk(6'(i));
    model_reset();
    rst_n       = 1'b0;
    i_read      = 1'b1;
    i_write     = 1'b0;
    i_address   = 8'h00;
    i_writedata = 8'h00;
    #3;
    take_snapshot();                   // outputs idle under reset, request held
    @(posedge clk);
    #1 i_read = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    do_op(1, 0, 8'h00, 8'h00);         // T1 cold read miss
    do_op(0, 1, 8'h05, 8'hAB);         // T2 clean write miss
    do_op(1, 0, 8'h05, 8'h00);         //    read-back hit
    for (int k = 4; k < 8; k++)        // T4 back-to-back hits
      do_op(1, 0, 8'(k), 8'h00);
    do_op(1, 0, 8'h25, 8'h00);         // T3 dirty eviction of block 0x01
    do_op(1, 1, 8'h10, 8'h5C);         // T6 read+write acts as write
    do_op(1, 0, 8'h30, 8'h00);         //    evicts dirty block 0x04
    do_op(1, 0, 8'h10, 8'h00);         //    refetch shows stored byte
    idle_cycle();

    // T5: index 2 is still invalid, so this miss goes straight to FETCH.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    i_read    = 1'b1;
    i_address = 8'h48;
    seen      = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (o_mem_read) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      $display("FAIL t5_fetch mem_read=%b required 1 within 10 cycles", o_mem_read);
      $fatal(1);
    end
    #2 rst_n = 1'b0;
    #1 take_snapshot();
    i_read = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    idle_cycle();
    mon_en = 1'b1;
    do_op(1, 0, 8'h48, 8'h00);         // misses again after reset

    for (int n = 0; n < 300; n++) begin
      a  = 8'($urandom_range(0, 127));
      d  = 8'($urandom);
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle_cycle();
      do_op(rd, wr, a, d);
    end
    idle_cycle();
    repeat (2) @(posedge clk);
    done_req = 1'b1;
  end

  // ---------------- monitor ----------------
  int checks = 0;
  int errors = 0;

  initial begin : monitor
    int    mon_stall = 0;
    int    snap_seen = 0;
    opx_t  o;
    memx_t mx;
    forever begin
      @(negedge clk);
      if (snap_req != snap_seen) begin
        checks++;
        if (snap_val != '0) begin
          errors++;
          $display("FAIL reset_outputs got=%h required=0", snap_val);
        end
        snap_seen = snap_req;
      end
      if (o_mem_read || o_mem_write) begin
        checks++;
        if (o_mem_read && o_mem_write) begin
          errors++;
          $display("FAIL mem_exclusive mem_read=%b mem_write=%b required not both 1",
                   o_mem_read, o_mem_write);
        end
        if (!mem_busywait) begin
          if (mem_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected wr=%b addr=%h required no transaction",
                     o_mem_write, o_mem_address);
          end else begin
            mx = mem_q.pop_front();
            checks++;
            if (mx.wr != o_mem_write || mx.addr != o_mem_address ||
                (mx.wr && mx.data != o_mem_writedata)) begin
              errors++;
              $display("FAIL mem_txn got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                       o_mem_write, o_mem_address, o_mem_writedata, mx.wr, mx.addr, mx.data);
            end
          end
        end
      end
      if (!rst_n || !mon_en) begin
        mon_stall = 0;
      end else if (i_read || i_write) begin
        if (o_busywait) begin
          mon_stall++;
        end else if (op_q.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected addr=%h required no completion", i_address);
        end else begin
          o = op_q.pop_front();
          checks++;
          if (o.stalls != mon_stall) begin
            errors++;
            $display("FAIL stall_cycles addr=%h got=%0d required=%0d", o.addr, mon_stall, o.stalls);
          end
          if (o.rd) begin
            checks++;
            if (o_readdata != o.data) begin
              errors++;
              $display("FAIL read_data addr=%h got=%h required=%h", o.addr, o_readdata, o.data);
            end
          end
          mon_stall = 0;
        end
      end
      if (done_req) begin
        checks++;
        if (op_q.size() != 0) begin
          errors++;
          $display("FAIL op_queue_drain got=%0d required=0", op_q.size());
        end
        checks++;
        if (mem_q.size() != 0) begin
          errors++;
          $display("FAIL mem_queue_drain got=%0d required=0", mem_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
